// File: rtl/hex_counter_mux.sv
// Multi-digit hex up/down counter with prescaled tick, clear/load, wrap pulse,
// and time-multiplexed common-anode seven-segment scan with optional leading-zero blanking.
module hex_counter_mux #(
   parameter int NDIGITS  = 4,
   parameter int PRESCALE = 50_000_000,
   parameter int SCAN_DIV = 50_000,
   parameter int BLANK_LZ = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   up,
   input  logic                   clr,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   load_val,
   output logic [4*NDIGITS-1:0]   value,
   output logic                   wrap,
   output logic [NDIGITS-1:0]     digit,
   output logic [6:0]             sseg,
   output logic                   dp
);

   localparam int W  = 4 * NDIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NDIGITS - 1);

   logic [W-1:0]       value_q, value_d;
   logic               wrap_q, wrap_d;
   logic [PW-1:0]      pre_q, pre_d;
   logic [SW-1:0]      scan_q, scan_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [NDIGITS-1:0] digit_q, digit_d;
   logic [6:0]         sseg_q, sseg_d;
   logic               dp_q, dp_d;

   logic               tick;
   logic [3:0]         nib;
   logic               upper_nz;
   logic               lead_zero;

   function automatic logic [6:0] seg_enc(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h01;
         4'h1: s = 7'h4F;
         4'h2: s = 7'h12;
         4'h3: s = 7'h06;
         4'h4: s = 7'h4C;
         4'h5: s = 7'h24;
         4'h6: s = 7'h20;
         4'h7: s = 7'h0F;
         4'h8: s = 7'h00;
         4'h9: s = 7'h04;
         4'hA: s = 7'h08;
         4'hB: s = 7'h60;
         4'hC: s = 7'h31;
         4'hD: s = 7'h42;
         4'hE: s = 7'h30;
         default: s = 7'h38;
      endcase
      return s;
   endfunction

   // A tick coinciding with clr/load is dropped: those branches win outright.
   always_comb begin
      tick    = en && (pre_q == PRE_MAX);
      pre_d   = pre_q;
      value_d = value_q;
      wrap_d  = 1'b0;
      if (clr) begin
         value_d = '0;
         pre_d   = '0;
      end else if (load) begin
         value_d = load_val;
         pre_d   = '0;
      end else if (en) begin
         if (tick) begin
            pre_d = '0;
            if (up) begin
               value_d = value_q + W'(1);
               wrap_d  = &value_q;
            end else begin
               value_d = value_q - W'(1);
               wrap_d  = ~|value_q;
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   always_comb begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SCAN_MAX) begin
         scan_d = '0;
         idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end
   end

   // Walk from the top digit down so upper_nz covers nibbles idx..NDIGITS-1 at the selected digit.
   always_comb begin
      nib       = 4'h0;
      upper_nz  = 1'b0;
      lead_zero = 1'b0;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         upper_nz = upper_nz | (value_q[4*i +: 4] != 4'h0);
         if (IW'(i) == idx_q) begin
            nib       = value_q[4*i +: 4];
            lead_zero = ~upper_nz;
         end
      end
      digit_d = ~(NDIGITS'(1) << idx_q);
      if ((BLANK_LZ != 0) && (idx_q != '0) && lead_zero)
         sseg_d = 7'h7F;
      else
         sseg_d = seg_enc(nib);
      dp_d = ~((idx_q == '0) && !en);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
         wrap_q  <= 1'b0;
         pre_q   <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         digit_q <= '1;
         sseg_q  <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         value_q <= value_d;
         wrap_q  <= wrap_d;
         pre_q   <= pre_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         sseg_q  <= sseg_d;
         dp_q    <= dp_d;
      end
   end

   assign value = value_q;
   assign wrap  = wrap_q;
   assign digit = digit_q;
   assign sseg  = sseg_q;
   assign dp    = dp_q;

endmodule

// File: tb/tb_hex_counter_mux.sv
// Bench for hex_counter_mux: directed scenarios plus random traffic against an arithmetic model.
module tb_hex_counter_mux;

   localparam int ND = 4;
   localparam int PS = 4;
   localparam int SD = 2;
   localparam logic [6:0] ENC [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                       7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   logic        clk = 1'b0;
   logic        reset, en, up, clr, load;
   logic [15:0] load_val;
   logic [15:0] value, value_nb;
   logic        wrap, wrap_nb, dp, dp_nb;
   logic [3:0]  digit, digit_nb;
   logic [6:0]  sseg, sseg_nb;

   hex_counter_mux #(.NDIGITS(ND), .PRESCALE(PS), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
      .value(value), .wrap(wrap), .digit(digit), .sseg(sseg), .dp(dp));

   hex_counter_mux #(.NDIGITS(ND), .PRESCALE(PS), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_nb (
      .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
      .value(value_nb), .wrap(wrap_nb), .digit(digit_nb), .sseg(sseg_nb), .dp(dp_nb));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   int       m_val, m_pre, m_cyc;
   bit       m_wrap;
   logic [3:0] e_digit;
   logic [6:0] e_sseg, e_sseg_nb;
   logic       e_dp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset();
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      chk("rst_digit", 32'(digit), 32'hF);
      chk("rst_sseg", 32'(sseg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
      chk("rst_sseg_nb", 32'(sseg_nb), 32'h7F);
   endtask

   task automatic model_clear();
      m_val  = 0;
      m_pre  = 0;
      m_cyc  = 0;
      m_wrap = 0;
   endtask

   // One clock: derive expectations from the model and current inputs, clock, then compare.
   task automatic cycle();
      int idx, upper, nv;
      idx       = (m_cyc / SD) % ND;
      upper     = m_val >> (4 * idx);
      e_digit   = 4'hF ^ 4'(1 << idx);
      e_sseg_nb = ENC[upper & 15];
      e_sseg    = (idx > 0 && upper == 0) ? 7'h7F : ENC[upper & 15];
      e_dp      = !(idx == 0 && !en);
      m_wrap    = 0;
      if (clr) begin
         m_val = 0;
         m_pre = 0;
      end else if (load) begin
         m_val = int'(load_val);
         m_pre = 0;
      end else if (en) begin
         m_pre++;
         if (m_pre == PS) begin
            m_pre  = 0;
            nv     = up ? m_val + 1 : m_val - 1;
            m_wrap = (nv < 0) || (nv > 65535);
            m_val  = (nv + 65536) % 65536;
         end
      end
      m_cyc++;
      @(posedge clk);
      #1;
      chk("value", 32'(value), 32'(m_val));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("digit", 32'(digit), 32'(e_digit));
      chk("sseg", 32'(sseg), 32'(e_sseg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("sseg_nb", 32'(sseg_nb), 32'(e_sseg_nb));
      chk("value_nb", 32'(value_nb), 32'(m_val));
      chk("wrap_nb", 32'(wrap_nb), 32'(m_wrap));
      chk("digit_nb", 32'(digit_nb), 32'(e_digit));
      chk("dp_nb", 32'(dp_nb), 32'(e_dp));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic align_tick();
      en = 1'b1;
      for (int k = 0; k < PS && m_pre != PS - 1; k++) cycle();
   endtask

   initial begin
      int wraps;
      reset = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_reset();
      reset = 1'b1;

      // Count up, then pause.
      en = 1'b1; up = 1'b1;
      run(16);
      chk("cnt16", 32'(value), 32'h4);
      en = 1'b0;
      run(10);
      chk("hold", 32'(value), 32'h4);

      // Up-wrap from FFFE.
      load_val = 16'hFFFE; load = 1'b1;
      cycle();
      load = 1'b0; en = 1'b1; up = 1'b1;
      wraps = 0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (wrap) wraps++;
      end
      chk("wrap_cnt", 32'(wraps), 32'h1);

      // Down-wrap from 0.
      clr = 1'b1;
      cycle();
      clr = 1'b0; up = 1'b0;
      run(4);
      chk("down_val", 32'(value), 32'hFFFF);

      // Scan and blanking with a static value.
      en = 1'b0; load_val = 16'h00A3; load = 1'b1;
      cycle();
      load = 1'b0;
      run(16);

      // clr+load on a tick edge, then load alone on a tick edge.
      up = 1'b1;
      align_tick();
      clr = 1'b1; load = 1'b1; load_val = 16'h1234;
      cycle();
      chk("prio_clr", 32'(value), 32'h0);
      clr = 1'b0; load = 1'b0;
      align_tick();
      load = 1'b1; load_val = 16'h5A5A;
      cycle();
      chk("prio_load", 32'(value), 32'h5A5A);
      load = 1'b0;
      run(6);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         en   = ($urandom % 4) != 0;
         up   = 1'($urandom % 2);
         clr  = ($urandom % 50) == 0;
         load = ($urandom % 25) == 0;
         case ($urandom % 4)
            0: load_val = 16'hFFFF;
            1: load_val = 16'h0000;
            default: load_val = 16'($urandom);
         endcase
         cycle();
      end
      clr = 1'b0; load = 1'b0;

      // Async reset between edges at value 7.
      clr = 1'b1;
      cycle();
      clr = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 0; k < 64 && m_val != 7; k++) cycle();
      chk("pre_rst_val", 32'(value), 32'h7);
      #2;
      reset = 1'b0;
      #1;
      check_reset();
      model_clear();
      @(posedge clk);
      #1;
      check_reset();
      reset = 1'b1;
      run(8);
      chk("restart", 32'(value), 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hex_counter_mux.md
# hex_counter_mux

Parametrised multi-digit hexadecimal counter that drives a time-multiplexed common-anode seven-segment display. It holds an NDIGITS×4-bit count that advances up or down on a prescaled tick. It supports synchronous clear, parallel load and wrap indication. It scans one digit at a time onto shared active-low segment lines, with optional leading-zero blanking. It replaces the single-digit free-running hex display in the board top level.

## Interface
- NDIGITS, 4: number of hex digits / anode lines (≥1)
- PRESCALE, 50_000_000: enabled clk cycles per count step (≥1; 1 = step every enabled cycle)
- SCAN_DIV, 50_000: clk cycles per displayed digit (≥1)
- BLANK_LZ, 1: 1 = blank leading zero digits; digit 0 is never blanked
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable; also gates the prescaler
- up  in  1  direction: 1 = increment, 0 = decrement
- clr  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous parallel load
- load_val  in  4*NDIGITS  value taken on load
- value  out  4*NDIGITS  current count
- wrap  out  1  one-cycle pulse on modulo wrap
- digit  out  NDIGITS  anode enables, active-low, one-hot-low while scanning
- sseg  out  7  segments, active-low, sseg[6]=a … sseg[0]=g
- dp  out  1  decimal point, active-low

## Operation
- Reset (async, reset=0): value=0, prescaler=0, scan counter=0, scan index=0, wrap=0, digit=all 1, sseg=7'h7F, dp=1. Outputs hold these values while reset=0.
- Priority each edge: clr > load > count.
- clr=1: value←0, prescaler←0, wrap←0.
- load=1 (clr=0): value←load_val, prescaler←0, wrap←0.
- Prescaler: increments only when en=1. At PRESCALE-1 with en=1 it returns to 0 and produces a tick. With en=0 it holds.
- On tick: value←value±1 modulo 2^(4·NDIGITS).
- wrap←1 for exactly one cycle if the step goes all-ones→0 (up) or 0→all-ones (down). Otherwise wrap←0.
- Scan counter runs continuously, 0..SCAN_DIV-1. At SCAN_DIV-1 the scan index advances 0→1→…→NDIGITS-1→0.
- Display registers are updated every cycle from the current scan index and value:
  - digit←~(1<<idx).
  - sseg←enc(value[4·idx+3:4·idx]).
  - dp←0 when idx=0 and en=0 (paused indicator), else 1.
- Blanking: with BLANK_LZ=1, idx>0 and nibbles idx..NDIGITS-1 all zero → sseg=7'h7F. digit still goes active.
- enc (active-low), nibble 0..F: 01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38 (hex).

## Timing
- value and wrap are registered. Step is visible the cycle after the edge where the prescaler is at PRESCALE-1 with en=1.
- First step after reset release with en held high: PRESCALE enabled cycles later.
- Display lags value and scan index by 1 cycle.
- Each digit is displayed for SCAN_DIV cycles. A full frame is NDIGITS·SCAN_DIV cycles.
- First edge after reset release: digit=~1, showing nibble 0.
- clr or load on a tick edge: the tick is discarded; clr/load result only, no wrap.
- en deasserted mid-period: the prescaler freezes and resumes from the held value.
- Async reset mid-count: all state goes to reset values immediately, without waiting for clk.
- Prescaler and scan counter widths are $clog2 of their limits, minimum 1 bit.

## Test plan
Use NDIGITS=4, PRESCALE=4, SCAN_DIV=2 unless stated.
- Reset: hold reset=0 → digit=4'hF, sseg=7'h7F, dp=1, value=0, wrap=0. After release, first edge → digit=4'b1110, sseg=7'h01.
- Count up: en=1, up=1 for 16 cycles → value=4, one step every 4th cycle. en=0 for 10 cycles → value holds at 4, dp=0 while idx=0.
- Wrap and direction:
  - load_val=16'hFFFE, load pulse, then en=1, up=1: value FFFF, then 0000, with wrap high exactly one cycle at that step.
  - From 0000 with up=0: value=FFFF and wrap pulses.
- Scan and blanking: value=16'h00A3, BLANK_LZ=1 → each for 2 cycles, then repeat:
  - digit 1110 / sseg 06
  - digit 1101 / sseg 08
  - digit 1011 / sseg 7F
  - digit 0111 / sseg 7F
  - With BLANK_LZ=0, digits 2 and 3 show sseg 01.
- Priority: clr=1 and load=1 on a tick edge → value=0, wrap=0. load alone on a tick edge → value=load_val, no increment.
- Async reset mid-count: drop reset between edges at value=7 → value=0 and display outputs go to reset values before the next clk edge. Counting restarts from 0 after release.
